// File: rtl/jtag_gpio_bank.sv
// jtag_gpio_bank
//   A JTAG-controlled GPIO bank. A 2-bit scan_n register picks which bank
//   register the data scan chain reaches:
//     0 = output enables, 1 = pin data, 2 = edge status, 3 = reserved.
//   A data scan captures the selected register. An EXTEST update writes it
//   back, but only when the write flag (dr MSB) is set.
//   Ports:
//     tck                  sole clock, rising edge
//     reset                asynchronous, active-high
//     tdi / gpios_tdo      scan data in / out
//     capture_dr, shift_dr, update_dr   TAP state flags
//     scan_n_ir, extest_ir, sample_ir   active-instruction decodes
//     gpio_inputs          asynchronous pin levels
//     gpio_outputs         registered output levels
//     gpio_oe              registered output enables (1 = drive)

// Per-pin slice: input synchroniser, edge latch, output and enable bits.
module jtag_gpio_lane #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic tck,
    input  logic reset,
    input  logic pin,
    input  logic oe_wr,
    input  logic out_wr,
    input  logic clr_wr,
    input  logic wbit,
    output logic out_q,
    output logic oe_q,
    output logic sync_q,
    output logic edge_q
);
    logic meta, sync_d;

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            sync_d <= 1'b0;
            out_q  <= RST_VAL;
            oe_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta   <= pin;
            sync_q <= meta;
            sync_d <= sync_q;
            if (out_wr) out_q <= wbit;
            if (oe_wr)  oe_q  <= wbit;
            // A fresh rising edge beats a write-1-to-clear in the same cycle,
            // so an event is never lost to a racing clear.
            if (sync_q && !sync_d)    edge_q <= 1'b1;
            else if (clr_wr && wbit)  edge_q <= 1'b0;
        end
    end
endmodule

module jtag_gpio_bank #(
    parameter int                   NR_GPIOS  = 8,
    parameter logic [NR_GPIOS-1:0]  OUT_RESET = '0
) (
    input  logic                tck,
    input  logic                reset,
    input  logic                tdi,
    output logic                gpios_tdo,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic                scan_n_ir,
    input  logic                extest_ir,
    input  logic                sample_ir,
    input  logic [NR_GPIOS-1:0] gpio_inputs,
    output logic [NR_GPIOS-1:0] gpio_outputs,
    output logic [NR_GPIOS-1:0] gpio_oe
);
    localparam logic [1:0] SEL_OE   = 2'd0;
    localparam logic [1:0] SEL_DATA = 2'd1;
    localparam logic [1:0] SEL_EDGE = 2'd2;

    logic [1:0]          scan_sr, scan_sel;
    logic [NR_GPIOS:0]   dr;
    logic [NR_GPIOS-1:0] sync, edge_status, cap_val;
    logic                dr_ir, wr_en, oe_wr, out_wr, clr_wr;

    assign dr_ir = extest_ir | sample_ir;

    // scan_n chain; capture has no meaning here but still blocks shift/update.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            scan_sr  <= 2'b00;
            scan_sel <= SEL_DATA;
        end else if (scan_n_ir && !capture_dr) begin
            if (shift_dr)       scan_sr  <= {tdi, scan_sr[1]};
            else if (update_dr) scan_sel <= scan_sr;
        end
    end

    always_comb begin
        cap_val = '0;
        case (scan_sel)
            SEL_OE:   cap_val = gpio_oe;
            SEL_DATA: cap_val = sync;
            SEL_EDGE: cap_val = edge_status;
            default:  cap_val = '0;
        endcase
    end

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            dr <= '0;
        end else if (dr_ir) begin
            if (capture_dr)    dr <= {1'b0, cap_val};
            else if (shift_dr) dr <= {tdi, dr[NR_GPIOS:1]};
        end
    end

    // Only EXTEST writes, only with the write flag set, and only when update
    // is not shadowed by a coincident capture or shift.
    assign wr_en  = extest_ir & update_dr & ~capture_dr & ~shift_dr & dr[NR_GPIOS];
    assign oe_wr  = wr_en & (scan_sel == SEL_OE);
    assign out_wr = wr_en & (scan_sel == SEL_DATA);
    assign clr_wr = wr_en & (scan_sel == SEL_EDGE);

    for (genvar g = 0; g < NR_GPIOS; g++) begin : g_lane
        jtag_gpio_lane #(.RST_VAL(OUT_RESET[g])) u_lane (
            .tck    (tck),
            .reset  (reset),
            .pin    (gpio_inputs[g]),
            .oe_wr  (oe_wr),
            .out_wr (out_wr),
            .clr_wr (clr_wr),
            .wbit   (dr[g]),
            .out_q  (gpio_outputs[g]),
            .oe_q   (gpio_oe[g]),
            .sync_q (sync[g]),
            .edge_q (edge_status[g])
        );
    end

    assign gpios_tdo = scan_n_ir ? scan_sr[0] : dr[0];
endmodule

// File: tb/tb_jtag_gpio_bank.sv
module tb_jtag_gpio_bank;
    localparam int         N    = 8;
    localparam logic [7:0] ORST = 8'h5A;

    logic       tck = 0, reset, tdi, gpios_tdo;
    logic       capture_dr, shift_dr, update_dr, scan_n_ir, extest_ir, sample_ir;
    logic [7:0] gpio_inputs, gpio_outputs, gpio_oe;

    jtag_gpio_bank #(.NR_GPIOS(N), .OUT_RESET(ORST)) dut (
        .tck(tck), .reset(reset), .tdi(tdi), .gpios_tdo(gpios_tdo),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .scan_n_ir(scan_n_ir), .extest_ir(extest_ir), .sample_ir(sample_ir),
        .gpio_inputs(gpio_inputs), .gpio_outputs(gpio_outputs), .gpio_oe(gpio_oe)
    );

    always #5 tck = ~tck;

    int nvec = 0, nerr = 0;

    // Reference state: what each bank register should hold.
    logic [7:0] m_out, m_oe, m_edge, m_prev, pins;
    logic [1:0] m_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    task automatic model_reset;
        m_out = ORST; m_oe = 0; m_edge = 0; m_sel = 2'd1; m_prev = 0;
    endtask

    // Hold pins long enough to pass the synchroniser; any 0->1 latches.
    task automatic settle;
        repeat (4) tick;
        m_edge |= pins & ~m_prev;
        m_prev = pins;
    endtask

    task automatic set_pins(input logic [7:0] p);
        pins = p;
        gpio_inputs = p;
        settle;
    endtask

    task automatic set_sel(input logic [1:0] v);
        scan_n_ir = 1; shift_dr = 1;
        tdi = v[0]; tick;
        tdi = v[1]; tick;
        shift_dr = 0;
        chk("sel_tdo", gpios_tdo, v[0]);
        update_dr = 1; tick;
        update_dr = 0; scan_n_ir = 0;
        m_sel = v;
    endtask

    // Full data scan: capture, 9 shifts (reading tdo), update.
    // 'rise' pins go high so their synchronised edge lands on the update edge.
    task automatic dr_scan(input bit ext, input logic [8:0] w, input logic [7:0] rise);
        logic [7:0] expcap, clr, newe;
        logic [8:0] rd;
        case (m_sel)
            2'd0: expcap = m_oe;
            2'd1: expcap = m_prev;
            2'd2: expcap = m_edge;
            default: expcap = 8'h00;
        endcase
        extest_ir = ext; sample_ir = !ext;
        capture_dr = 1; tick; capture_dr = 0;
        shift_dr = 1;
        for (int i = 0; i <= N; i++) begin
            rd[i] = gpios_tdo;
            if (i == N - 1 && rise != 0) begin
                pins = pins | rise;
                gpio_inputs = pins;
            end
            tdi = w[i];
            tick;
        end
        shift_dr = 0;
        chk("capture", rd, {1'b0, expcap});
        chk("pre_out", gpio_outputs, m_out);
        chk("pre_oe", gpio_oe, m_oe);
        update_dr = 1; tick;
        update_dr = 0; extest_ir = 0; sample_ir = 0;
        clr = 0;
        if (ext && w[8]) begin
            case (m_sel)
                2'd0: m_oe = w[7:0];
                2'd1: m_out = w[7:0];
                2'd2: clr = w[7:0];
                default: ;
            endcase
        end
        newe = rise & ~m_prev;
        m_edge = (m_edge & ~clr) | newe;
        m_prev = pins;
        chk("out", gpio_outputs, m_out);
        chk("oe", gpio_oe, m_oe);
    endtask

    task automatic reset_mid_shift;
        extest_ir = 1;
        capture_dr = 1; tick; capture_dr = 0;
        shift_dr = 1;
        repeat (4) begin tdi = 1'($urandom); tick; end
        #2 reset = 1;
        #1;
        chk("rst_mid_out", gpio_outputs, ORST);
        chk("rst_mid_oe", gpio_oe, 8'h00);
        chk("rst_mid_tdo", gpios_tdo, 1'b0);
        shift_dr = 0; extest_ir = 0;
        tick;
        reset = 0;
        model_reset;
        settle;
    endtask

    initial begin
        reset = 1; tdi = 0;
        capture_dr = 0; shift_dr = 0; update_dr = 0;
        scan_n_ir = 0; extest_ir = 0; sample_ir = 0;
        pins = 0; gpio_inputs = 0;
        model_reset;
        tick; tick;
        chk("rst_out", gpio_outputs, ORST);
        chk("rst_oe", gpio_oe, 8'h00);
        chk("rst_tdo", gpios_tdo, 1'b0);
        reset = 0;
        settle;

        // write data then enables
        set_sel(2'd1); dr_scan(1, 9'h1A5, 0);
        set_sel(2'd0); dr_scan(1, 9'h1A5, 0);
        // read-only scan of pins, no write flag
        set_pins(8'h3C);
        set_sel(2'd1); dr_scan(1, 9'h000, 0);
        // edge status: clear, single rise, read + clear, set-vs-clear race
        set_pins(8'h00);
        set_sel(2'd2); dr_scan(1, 9'h1FF, 0);
        set_pins(8'h04);
        dr_scan(1, 9'h104, 0);
        dr_scan(1, 9'h000, 0);
        set_pins(8'h00);
        dr_scan(1, 9'h104, 8'h04);
        dr_scan(1, 9'h000, 0);
        // sample is read-only
        set_sel(2'd1); dr_scan(0, 9'h1FF, 0);
        set_sel(2'd0); dr_scan(0, 9'h1FF, 0);
        // reset during shift; selection must fall back to data
        set_pins(8'hC3);
        reset_mid_shift;
        dr_scan(1, 9'h1E7, 0);
        dr_scan(1, 9'h000, 0);

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: set_pins(8'($urandom));
                1: set_sel(2'($urandom));
                2: dr_scan(1, 9'($urandom), 0);
                default: dr_scan(0, 9'($urandom), 0);
            endcase
        end
        // final sweep of all readable registers
        for (int s = 0; s < 3; s++) begin
            set_sel(2'(s));
            dr_scan(1, 9'h000, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
